mem_port_arbiter: RTL and testbench

Arbitrates one synchronous single-port RAM between two requesters: the single-cycle RISC-V core (port C) and the FPGA pushbutton/calculator host (port H), which loads and inspects memory. It replaces the static enable-driven mux on address, write-data and write-enable with a sequenced grant/acknowledge handshake. It also drives a stall so the core freezes while its access is pending. It sits in `top1`, between the core's data port, the host module and the RAM.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 28 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        PORT_C = 1'b0,
        PORT_H = 1'b1
    } port_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin chooser; on a tie the
//               requester that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic       valid,
    output port_id_t   winner
);

    always_comb begin
        valid  = |req;
        winner = PORT_C;
        if (req == 2'b11) begin
            winner = (last == PORT_C) ? PORT_H : PORT_C;
        end else if (req[1]) begin
            winner = PORT_H;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Grant/acknowledge arbiter sharing one synchronous single-port
//               RAM between the core (port C) and the host (port H).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state_q, w_state_d;
    port_id_t          r_owner_q, w_owner_d;
    port_id_t          r_last_q,  w_last_d;
    logic              r_mem_en_q,    w_mem_en_d;
    logic              r_mem_we_q,    w_mem_we_d;
    logic [ADDR_W-1:0] r_mem_addr_q,  w_mem_addr_d;
    logic [DATA_W-1:0] r_mem_wdata_q, w_mem_wdata_d;

    logic              w_in_resp;
    logic [1:0]        w_elig;
    logic              w_pick_valid;
    port_id_t          w_pick;

    // The port being acked is masked so it cannot win twice back-to-back.
    always_comb begin
        w_in_resp = (r_state_q == RESP);
        w_elig[0] = cpu_req & ~host_lock & ~(w_in_resp & (r_owner_q == PORT_C));
        w_elig[1] = host_req & ~(w_in_resp & (r_owner_q == PORT_H));
    end

    rr_pick2 u_pick (
        .req    (w_elig),
        .last   (r_last_q),
        .valid  (w_pick_valid),
        .winner (w_pick)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_owner_d     = r_owner_q;
        w_last_d      = r_last_q;
        w_mem_en_d    = 1'b0;
        w_mem_we_d    = 1'b0;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;

        case (r_state_q)
            GRANT: begin
                w_state_d = RESP;
            end
            default: begin
                // IDLE and RESP both arbitrate; an undefined state falls here too.
                if (w_pick_valid) begin
                    w_state_d     = GRANT;
                    w_owner_d     = w_pick;
                    w_last_d      = w_pick;
                    w_mem_en_d    = 1'b1;
                    w_mem_we_d    = (w_pick == PORT_C) ? cpu_we     : host_we;
                    w_mem_addr_d  = (w_pick == PORT_C) ? cpu_addr   : host_addr;
                    w_mem_wdata_d = (w_pick == PORT_C) ? cpu_wdata  : host_wdata;
                end else begin
                    w_state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_owner_q     <= PORT_C;
            r_last_q      <= PORT_H;
            r_mem_en_q    <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_owner_q     <= w_owner_d;
            r_last_q      <= w_last_d;
            r_mem_en_q    <= w_mem_en_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
        end
    end

    assign mem_en     = r_mem_en_q;
    assign mem_we     = r_mem_we_q;
    assign mem_addr   = r_mem_addr_q;
    assign mem_wdata  = r_mem_wdata_q;

    assign cpu_ack    = w_in_resp & (r_owner_q == PORT_C);
    assign host_ack   = w_in_resp & (r_owner_q == PORT_H);
    assign cpu_stall  = cpu_req & ~cpu_ack;
    assign cpu_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a bench-side
//               RAM and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_aw = 32;
    localparam int c_dw = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cpu_req = 1'b0, cpu_we = 1'b0;
    logic [c_aw-1:0] cpu_addr = '0;
    logic [c_dw-1:0] cpu_wdata = '0;
    logic            cpu_ack, cpu_stall;
    logic [c_dw-1:0] cpu_rdata;
    logic            host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [c_aw-1:0] host_addr = '0;
    logic [c_dw-1:0] host_wdata = '0;
    logic            host_ack;
    logic [c_dw-1:0] host_rdata;
    logic            mem_en, mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic [c_dw-1:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(c_aw), .DATA_W(c_dw)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_lock  (host_lock),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [c_dw-1:0] ram [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[5:0]];
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an access is an issue cycle followed by a response cycle.
    logic [c_dw-1:0] shadow [64];
    bit              m_busy = 0, m_resp = 0, m_we = 0;
    int              m_port = 0, m_last = 1;
    logic [c_aw-1:0] m_addr = '0;
    logic [c_dw-1:0] m_wdata = '0, m_rdata = '0;
    bit              chk_en = 0;
    bit              ack_c_prev = 0, ack_h_prev = 0;
    int              ack_q[$];
    int              ack_t[$];
    int              cyc = 0;
    int              c_wait = 0, h_wait = 0;

    always @(negedge clk) begin
        bit e_en, e_cack, e_hack, want_c, want_h;
        int p;
        cyc++;
        e_en   = m_busy && !m_resp;
        e_cack = m_busy && m_resp && (m_port == 0);
        e_hack = m_busy && m_resp && (m_port == 1);
        if (chk_en) begin
            check_eq("mem_en",    mem_en,    e_en);
            check_eq("mem_we",    mem_we,    e_en && m_we);
            check_eq("mem_addr",  mem_addr,  m_addr);
            check_eq("mem_wdata", mem_wdata, m_wdata);
            check_eq("cpu_ack",   cpu_ack,   e_cack);
            check_eq("host_ack",  host_ack,  e_hack);
            check_eq("cpu_stall", cpu_stall, cpu_req & ~e_cack);
            check_eq("rdata_pass", {cpu_rdata ^ mem_rdata} | {host_rdata ^ mem_rdata}, 32'h0);
            if (e_cack && !m_we) check_eq("cpu_rdata",  cpu_rdata,  m_rdata);
            if (e_hack && !m_we) check_eq("host_rdata", host_rdata, m_rdata);
            c_wait = (!cpu_req || cpu_ack || host_lock || reset) ? 0 : c_wait + 1;
            h_wait = (!host_req || host_ack || reset) ? 0 : h_wait + 1;
            check_eq("c_starve", c_wait > 10, 0);
            check_eq("h_starve", h_wait > 10, 0);
        end
        ack_c_prev = cpu_ack;
        ack_h_prev = host_ack;
        if (cpu_ack)  begin ack_q.push_back(0); ack_t.push_back(cyc); end
        if (host_ack) begin ack_q.push_back(1); ack_t.push_back(cyc); end

        // The RAM performs the issued access at the coming edge, reset or not.
        if (e_en) begin
            if (m_we) shadow[m_addr[5:0]] = m_wdata;
            else      m_rdata = shadow[m_addr[5:0]];
        end
        if (reset) begin
            m_busy = 0; m_resp = 0; m_last = 1; m_we = 0;
            m_addr = '0; m_wdata = '0;
        end else if (e_en) begin
            m_resp = 1;
        end else begin
            want_c = cpu_req && !host_lock && !(m_busy && m_port == 0);
            want_h = host_req && !(m_busy && m_port == 1);
            if (want_c && want_h) p = 1 - m_last;
            else if (want_c)      p = 0;
            else if (want_h)      p = 1;
            else                  p = -1;
            if (p < 0) begin
                m_busy = 0; m_resp = 0;
            end else begin
                m_busy = 1; m_resp = 0; m_port = p; m_last = p;
                m_we    = (p == 0) ? cpu_we    : host_we;
                m_addr  = (p == 0) ? cpu_addr  : host_addr;
                m_wdata = (p == 0) ? cpu_wdata : host_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_cpu();
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 63)); cpu_wdata = $urandom;
    endtask

    task automatic new_host();
        host_req = 1; host_we = 1'($urandom_range(0, 1));
        host_addr = 32'($urandom_range(0, 63)); host_wdata = $urandom;
    endtask

    initial begin
        int hw;
        bit got;
        for (int i = 0; i < 64; i++) begin
            ram[i]    <= 32'(i) * 32'h0101_0101;
            shadow[i]  = 32'(i) * 32'h0101_0101;
        end
        ram[16]    <= 32'hDEAD_BEEF;
        shadow[16]  = 32'hDEAD_BEEF;

        repeat (2) tick();
        chk_en = 1;
        tick(); reset = 0;
        tick();

        // Single CPU read from idle
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        tick();
        check_eq("rd_en_c1",    mem_en,    1);
        check_eq("rd_addr_c1",  mem_addr,  32'h10);
        check_eq("rd_stall_c1", cpu_stall, 1);
        tick();
        check_eq("rd_ack_c2",   cpu_ack,   1);
        check_eq("rd_data_c2",  cpu_rdata, 32'hDEAD_BEEF);
        check_eq("rd_stall_c2", cpu_stall, 0);
        cpu_req = 0;
        tick();

        // Write then read back
        tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5_A5A5;
        tick();
        check_eq("wr_en",  mem_en, 1);
        check_eq("wr_we",  mem_we, 1);
        tick();
        check_eq("wr_ack", cpu_ack, 1);
        cpu_we = 0;
        tick();
        check_eq("wr_we_after", mem_we, 0);
        tick();
        check_eq("rb_en", mem_en, 1);
        check_eq("rb_we", mem_we, 0);
        tick();
        check_eq("rb_ack",  cpu_ack,   1);
        check_eq("rb_data", cpu_rdata, 32'hA5A5_A5A5);
        cpu_req = 0;
        tick();

        // Reset during the GRANT of a host write
        tick(); host_req = 1; host_we = 1; host_addr = 32'h5; host_wdata = 32'h55;
        tick();
        check_eq("rst_pre_en", mem_en, 1);
        check_eq("rst_pre_we", mem_we, 1);
        reset = 1; host_req = 0;
        tick();
        check_eq("rst_en",    mem_en,    0);
        check_eq("rst_we",    mem_we,    0);
        check_eq("rst_hack",  host_ack,  0);
        check_eq("rst_addr",  mem_addr,  0);
        check_eq("rst_wdata", mem_wdata, 0);
        reset = 0;
        tick();

        // First tie after reset goes to the core
        tick();
        cpu_req = 1;  cpu_we = 0;  cpu_addr = 32'h4;
        host_req = 1; host_we = 0; host_addr = 32'h8;
        tick();
        check_eq("tie_addr_c", mem_addr, 32'h4);
        tick();
        check_eq("tie_cack", cpu_ack,  1);
        check_eq("tie_hack", host_ack, 0);
        cpu_req = 0;
        tick();
        check_eq("tie_h_en",   mem_en,   1);
        check_eq("tie_h_addr", mem_addr, 32'h8);
        tick();
        check_eq("tie_h_ack",  host_ack,  1);
        check_eq("tie_h_data", host_rdata, 32'h0808_0808);
        host_req = 0;
        tick();

        // Sustained contention: eight accesses with both requests held
        ack_q.delete(); ack_t.delete();
        tick(); new_cpu(); new_host();
        for (int k = 0; k < 60 && (cpu_req || host_req); k++) begin
            tick();
            if (ack_c_prev) begin if (ack_q.size() >= 8) cpu_req = 0;  else new_cpu();  end
            if (ack_h_prev) begin if (ack_q.size() >= 8) host_req = 0; else new_host(); end
        end
        check_eq("sus_count", ack_q.size() >= 8, 1);
        for (int i = 0; i < 8 && i < ack_q.size(); i++)
            check_eq("sus_order", 32'(ack_q[i]), 32'(i % 2));
        for (int i = 1; i < 8 && i < ack_t.size(); i++)
            check_eq("sus_spacing", 32'(ack_t[i] - ack_t[i-1]), 2);
        cpu_req = 0; host_req = 0;
        tick(); tick();

        // Host lock: only host writes complete, core stays stalled
        ack_q.delete();
        host_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
        host_req = 1; host_we = 1; host_addr = 32'h0; host_wdata = 32'h1;
        hw = 0;
        for (int k = 0; k < 30 && hw < 3; k++) begin
            tick();
            check_eq("lock_stall", cpu_stall, 1);
            if (ack_h_prev) begin
                hw++;
                if (hw < 3) begin host_addr = 32'(hw); host_wdata = 32'(hw + 1); end
                else begin host_req = 0; host_lock = 0; end
            end
        end
        check_eq("lock_hwrites", ack_q.size(), 3);
        for (int i = 0; i < ack_q.size(); i++) check_eq("lock_port", 32'(ack_q[i]), 1);
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (cpu_ack) begin
                got = 1;
                check_eq("unlock_data", cpu_rdata, 32'h1);
                cpu_req = 0;
            end
        end
        check_eq("unlock_ack", got, 1);
        tick();

        // Randomized traffic with occasional lock toggles
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (cpu_req) begin
                if (ack_c_prev) begin if ($urandom_range(0, 1) == 0) cpu_req = 0; else new_cpu(); end
            end else if ($urandom_range(0, 3) == 0) new_cpu();
            if (host_req) begin
                if (ack_h_prev) begin if ($urandom_range(0, 1) == 0) host_req = 0; else new_host(); end
            end else if ($urandom_range(0, 3) == 0) new_host();
            if ($urandom_range(0, 31) == 0) host_lock = ~host_lock;
        end
        host_lock = 0;
        for (int k = 0; k < 20 && (cpu_req || host_req); k++) begin
            tick();
            if (ack_c_prev) cpu_req = 0;
            if (ack_h_prev) host_req = 0;
        end
        check_eq("drain", {cpu_req, host_req}, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
